// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next instruction word address from
// increment/branch sources, pulses the link write for calls, and counts retired instructions.
module pc_sequencer #(
   parameter int                     PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 halt,
   input  logic                 resume,
   input  logic                 ShortBr_out,
   input  logic [15:0]          short_off,
   input  logic                 long_br,
   input  logic [25:0]          long_off,
   input  logic                 reg_br,
   input  logic [PC_WIDTH-1:0]  reg_target,
   input  logic                 call,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  link_addr,
   output logic                 link_we,
   output logic                 fetch_en,
   output logic                 halted,
   output logic [PC_WIDTH-1:0]  instr_count
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] cnt_q, cnt_d;
   logic                advancing;
   logic [PC_WIDTH-1:0] short_sext, long_sext, pc_inc;

   // Offsets are relative to the current pc, not the fall-through address.
   assign short_sext = {{(PC_WIDTH-16){short_off[15]}}, short_off};
   assign long_sext  = {{(PC_WIDTH-26){long_off[25]}}, long_off};
   assign pc_inc     = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
   assign advancing  = (state_q == ST_RUN) && !stall;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (advancing) begin
               cnt_d = cnt_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
               if (halt)             state_d = ST_HALTED;
               else if (reg_br)      pc_d = reg_target;
               else if (long_br)     pc_d = pc_q + long_sext;
               else if (ShortBr_out) pc_d = pc_q + short_sext;
               else                  pc_d = pc_inc;
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_d = ST_RUN;
               pc_d    = pc_inc;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc          = pc_q;
   assign link_addr   = pc_inc;
   assign link_we     = advancing && long_br && call && !halt && !reg_br;
   assign fetch_en    = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALTED);
   assign instr_count = cnt_q;

endmodule
